// File: rtl/vsc8541_pkg.sv
// Shared types and 125 MHz timing constants for the VSC8541 PHY reset sequencer.
package vsc8541_pkg;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_HOLD,
        ST_WAIT,
        ST_READY
    } seq_state_e;

    typedef struct packed {
        logic rxd5;
        logic rxd4;
        logic rx_clk;
    } strap_t;

    localparam logic [2:0] STRAP_DEFAULT_C = 3'b001;

    // 10 us reset, 128 ns strap hold, 20 us settle at 125 MHz
    localparam int PHY_RESET_CYCLES_125M      = 1250;
    localparam int PHY_STRAP_HOLD_CYCLES_125M = 16;
    localparam int PHY_READY_WAIT_CYCLES_125M = 2500;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phy_delay_counter.sv
// Clearable up-counter with terminal-count compare; holds at the terminal value.
module phy_delay_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    assign tc_o = (cnt_q == term_i);

    always_ff @(posedge clk) begin
        if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !tc_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/vsc8541_reset_seq.sv
// VSC8541 power-up sequencer: nRESET timing, strap drive/release, ready flag.
// Optional runtime restart with new straps when VSC8541_RESTART_EN is defined.
module vsc8541_reset_seq
    import vsc8541_pkg::*;
#(
    parameter int         RESET_CYCLES      = PHY_RESET_CYCLES_125M,
    parameter int         STRAP_HOLD_CYCLES = PHY_STRAP_HOLD_CYCLES_125M,
    parameter int         READY_WAIT_CYCLES = PHY_READY_WAIT_CYCLES_125M,
    parameter logic [2:0] STRAP_DEFAULT     = STRAP_DEFAULT_C
) (
    input  logic       clk,
    input  logic       i_reset,
`ifdef VSC8541_RESTART_EN
    input  logic       i_restart,
`endif
    input  logic [2:0] i_strap,
    output logic       o_nreset,
    output logic       o_strap_oe,
    output logic       o_rx_clk,
    output logic       o_rx_d4,
    output logic       o_rx_d5,
    output logic       o_ready,
    output logic       o_busy
);

    localparam int MAX_CYCLES = max3(RESET_CYCLES, STRAP_HOLD_CYCLES, READY_WAIT_CYCLES);
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] TERM_RESET = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TERM_HOLD  = CW'(STRAP_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TERM_WAIT  = CW'(READY_WAIT_CYCLES - 1);

    if (RESET_CYCLES < 1 || STRAP_HOLD_CYCLES < 1 || READY_WAIT_CYCLES < 1) begin : g_param_check
        $error("vsc8541_reset_seq: all *_CYCLES parameters must be >= 1");
    end

    seq_state_e    state_q, state_d;
    strap_t        strap_q, strap_d;
    logic          nreset_q;
    logic          strap_oe_q;
    logic          ready_q;
    logic          busy_q;

    logic [CW-1:0] term;
    logic          tc;
    logic          cnt_clear;
    logic          cnt_en;

`ifndef VSC8541_RESTART_EN
    logic unused_strap;
    assign unused_strap = ^i_strap;
`endif

    always_comb begin
        state_d = state_q;
        strap_d = strap_q;
        term    = '0;
        unique case (state_q)
            ST_RESET: begin
                term = TERM_RESET;
                if (tc) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                term = TERM_HOLD;
                if (tc) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                term = TERM_WAIT;
                if (tc) state_d = ST_READY;
            end
            default: begin
                term = '0;
            end
        endcase
`ifdef VSC8541_RESTART_EN
        // Restart only once nRESET is released and the hold window is over
        if (i_restart && (state_q == ST_WAIT || state_q == ST_READY)) begin
            state_d = ST_RESET;
            strap_d = strap_t'(i_strap);
        end
`endif
    end

    assign cnt_clear = i_reset || (state_d != state_q);
    assign cnt_en    = (state_q != ST_READY);

    phy_delay_counter #(
        .WIDTH (CW)
    ) u_delay (
        .clk     (clk),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .term_i  (term),
        .tc_o    (tc)
    );

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= ST_RESET;
            strap_q    <= strap_t'(STRAP_DEFAULT);
            nreset_q   <= 1'b0;
            strap_oe_q <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            strap_q    <= strap_d;
            nreset_q   <= (state_d != ST_RESET);
            strap_oe_q <= (state_d == ST_RESET) || (state_d == ST_HOLD);
            ready_q    <= (state_d == ST_READY);
            busy_q     <= (state_d != ST_READY);
        end
    end

    assign o_nreset   = nreset_q;
    assign o_strap_oe = strap_oe_q;
    assign o_rx_clk   = strap_q.rx_clk;
    assign o_rx_d4    = strap_q.rxd4;
    assign o_rx_d5    = strap_q.rxd5;
    assign o_ready    = ready_q;
    assign o_busy     = busy_q;

endmodule
